// File: rtl/zbt_port_arbiter_pkg.sv
// Shared definitions for the ZBT port arbiter: bus widths, the starvation
// FSM state type and the {addr,data} word buffered in the write FIFO.
package zbt_port_arbiter_pkg;

  localparam int ZBT_AW = 19;
  localparam int ZBT_DW = 36;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_FORCE_WR = 1'b1
  } arb_state_e;

  // 55-bit FIFO entry, address in the upper bits
  typedef struct packed {
    logic [ZBT_AW-1:0] addr;
    logic [ZBT_DW-1:0] data;
  } wr_word_t;

endpackage

// File: rtl/zbt_port_arbiter_wr_fifo.sv
// Synchronous write FIFO holding NTSC {addr,data} words until a ZBT slot is free.
// No fall-through: a word pushed into an empty FIFO is visible at the head the
// following cycle. The caller guarantees push only when not full (or popping)
// and pop only when not empty.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push_i / wdata_i  enqueue a word
//   pop_i / rdata_o   dequeue the head word (rdata_o is the current head)
//   full_o, empty_o   occupancy flags
//   level_o           current occupancy, 0..2**AW
module zbt_port_arbiter_wr_fifo
  import zbt_port_arbiter_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  wr_word_t      wdata_i,
  input  logic          pop_i,
  output wr_word_t      rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int DEPTH = 2 ** AW;

  wr_word_t        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     level_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/zbt_port_arbiter.sv
// Shares the single ZBT SRAM port between the NTSC capture writer and the VGA
// display reader. Reads win each slot; writes are buffered and use idle slots,
// except when a write has waited long enough that it is forced ahead of reads.
// Write data is driven RD_LAT cycles after its address; read data is captured
// RD_LAT cycles after its address and presented one cycle later.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   wr_en/wr_addr/wr_data         NTSC write strobe and word
//   rd_req/rd_addr, rd_ack        display read request, held until rd_ack
//   rd_valid/rd_data              returned read word (1-cycle pulse)
//   mem_addr/mem_we               registered ZBT address and write enable
//   mem_wdata/mem_wdata_oe        registered ZBT write data and bus drive enable
//   mem_rdata                     ZBT read data
//   ovf_clr/wr_ovf                sticky FIFO overflow flag and its clear
//   fifo_level                    write FIFO occupancy
module zbt_port_arbiter
  import zbt_port_arbiter_pkg::*;
#(
  parameter int WFIFO_AW   = 3,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ZBT_AW-1:0] wr_addr,
  input  logic [ZBT_DW-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ZBT_AW-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [ZBT_DW-1:0] rd_data,
  output logic [ZBT_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [ZBT_DW-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [ZBT_DW-1:0] mem_rdata,
  input  logic              ovf_clr,
  output logic              wr_ovf,
  output logic [WFIFO_AW:0] fifo_level
);

  localparam int SCW = $clog2(STARVE_MAX) + 1;

  wr_word_t          fifo_in;
  wr_word_t          fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  arb_state_e        state_q;
  logic [SCW-1:0]    starve_q;
  logic [SCW-1:0]    starve_d;

  logic              wr_slot;
  logic              rd_slot;

  logic [ZBT_AW-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [ZBT_DW-1:0] wd_q [RD_LAT+1];
  logic [RD_LAT:0]   woe_q;
  logic [RD_LAT:0]   rv_q;
  logic              rd_valid_q;
  logic [ZBT_DW-1:0] rd_data_q;
  logic              wr_ovf_q;

  assign fifo_in = {wr_addr, wr_data};

  zbt_port_arbiter_wr_fifo #(.AW(WFIFO_AW)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    wr_slot = 1'b0;
    rd_slot = 1'b0;
    if (state_q == ST_FORCE_WR && !fifo_empty) wr_slot = 1'b1;
    else if (rd_req)                           rd_slot = 1'b1;
    else if (!fifo_empty)                      wr_slot = 1'b1;
  end

  // Gated by rst_n so the combinational grant is also quiet while in reset.
  assign rd_ack    = rd_slot & rst_n;
  assign fifo_pop  = wr_slot;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign fifo_push = wr_en & (~fifo_full | fifo_pop);

  always_comb begin
    starve_d = starve_q + 1'b1;
    if (fifo_empty || wr_slot) starve_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_NORMAL:   if (starve_d == SCW'(STARVE_MAX - 1)) state_q <= ST_FORCE_WR;
        ST_FORCE_WR: if (wr_slot || fifo_empty)            state_q <= ST_NORMAL;
        default:                                           state_q <= ST_NORMAL;
      endcase
    end
  end

  // Stage 0 of each shift register lines up with mem_addr; stage RD_LAT is
  // the data phase of that slot on the ZBT bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      woe_q      <= '0;
      rv_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ovf_q   <= 1'b0;
      for (int i = 0; i <= RD_LAT; i++) wd_q[i] <= '0;
    end else begin
      if (wr_slot)      mem_addr_q <= fifo_head.addr;
      else if (rd_slot) mem_addr_q <= rd_addr;
      mem_we_q <= wr_slot;
      woe_q    <= {woe_q[RD_LAT-1:0], wr_slot};
      rv_q     <= {rv_q[RD_LAT-1:0], rd_slot};
      wd_q[0]  <= wr_slot ? fifo_head.data : '0;
      for (int i = 1; i <= RD_LAT; i++) wd_q[i] <= wd_q[i-1];
      rd_valid_q <= rv_q[RD_LAT];
      if (rv_q[RD_LAT]) rd_data_q <= mem_rdata;
      if (wr_en && fifo_full && !fifo_pop) wr_ovf_q <= 1'b1;
      else if (ovf_clr)                    wr_ovf_q <= 1'b0;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = wd_q[RD_LAT];
  assign mem_wdata_oe = woe_q[RD_LAT];
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign wr_ovf       = wr_ovf_q;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Bench for zbt_port_arbiter: a cycle scoreboard driven by a queue-based model of
// the slot rules, a pipelined ZBT memory model, and per-scenario directed checks.
module tb_zbt_port_arbiter;
  import zbt_port_arbiter_pkg::*;

  localparam int WFIFO_AW   = 3;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 16;
  localparam int DEPTH      = 2 ** WFIFO_AW;
  localparam int MAXC       = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en, rd_req, ovf_clr;
  logic [18:0]       wr_addr, rd_addr;
  logic [35:0]       wr_data, mem_rdata;
  logic              rd_ack, rd_valid, mem_we, mem_wdata_oe, wr_ovf;
  logic [35:0]       rd_data, mem_wdata;
  logic [18:0]       mem_addr;
  logic [WFIFO_AW:0] fifo_level;

  zbt_port_arbiter #(.WFIFO_AW(WFIFO_AW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata), .ovf_clr(ovf_clr),
    .wr_ovf(wr_ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // samples of the most recent cycle
  logic              s_rd_ack, s_rd_valid, s_mem_we, s_oe, s_ovf;
  logic [35:0]       s_rd_data, s_mem_wdata;
  logic [18:0]       s_mem_addr;
  logic [WFIFO_AW:0] s_level;

  // reference model state
  wr_word_t    m_q[$];
  int          m_wait;
  bit          m_ovf;
  logic [18:0] m_last;
  logic [35:0] wmem [logic [18:0]];
  logic [35:0] zmem [logic [18:0]];

  bit          e_we [MAXC];
  logic [18:0] e_addr [MAXC];
  bit          e_oe [MAXC];
  logic [35:0] e_wd [MAXC];
  bit          e_rv [MAXC];
  logic [35:0] e_rd [MAXC];
  logic [18:0] zh_addr [MAXC];
  bit          zh_we [MAXC];

  function automatic logic [35:0] zread(input logic [18:0] a);
    if (zmem.exists(a)) return zmem[a];
    return {17'h1A5A5, a};
  endfunction

  function automatic logic [18:0] raddr();
    return {2'b01, 17'($urandom)};
  endfunction

  function automatic logic [18:0] waddr();
    return {1'b1, 18'($urandom)};
  endfunction

  function automatic logic [35:0] rdat();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    wmem.delete();
    m_wait = 0;
    m_ovf  = 1'b0;
    m_last = '0;
    for (int i = 0; i < MAXC; i++) begin
      e_we[i] = 0; e_addr[i] = '0; e_oe[i] = 0; e_wd[i] = '0;
      e_rv[i] = 0; e_rd[i] = '0; zh_addr[i] = '0; zh_we[i] = 0;
    end
  endtask

  // One clock cycle: sample, run ZBT model, compare against the reference, advance.
  task automatic tick();
    bit       mw, mr, drop;
    int       sz;
    wr_word_t head, nw;
    @(negedge clk);
    s_rd_ack = rd_ack; s_rd_valid = rd_valid; s_rd_data = rd_data;
    s_mem_addr = mem_addr; s_mem_we = mem_we; s_mem_wdata = mem_wdata;
    s_oe = mem_wdata_oe; s_level = fifo_level; s_ovf = wr_ovf;
    zh_addr[cyc] = mem_addr;
    zh_we[cyc]   = mem_we;
    if (mem_wdata_oe && cyc >= RD_LAT && zh_we[cyc-RD_LAT]) zmem[zh_addr[cyc-RD_LAT]] = mem_wdata;

    sz   = m_q.size();
    head = (sz > 0) ? m_q[0] : '0;
    mw = 0; mr = 0;
    if (sz > 0 && m_wait >= STARVE_MAX - 1) mw = 1;
    else if (rd_req)                        mr = 1;
    else if (sz > 0)                        mw = 1;

    n_checks++;
    if (s_rd_ack !== mr) begin
      n_fail++; $display("FAIL rd_ack cyc=%0d got=%b exp=%b", cyc, s_rd_ack, mr);
    end
    n_checks++;
    if (s_mem_we !== e_we[cyc]) begin
      n_fail++; $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, s_mem_we, e_we[cyc]);
    end
    n_checks++;
    if (s_mem_addr !== e_addr[cyc]) begin
      n_fail++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, s_mem_addr, e_addr[cyc]);
    end
    n_checks++;
    if (s_oe !== e_oe[cyc]) begin
      n_fail++; $display("FAIL mem_wdata_oe cyc=%0d got=%b exp=%b", cyc, s_oe, e_oe[cyc]);
    end
    if (e_oe[cyc]) begin
      n_checks++;
      if (s_mem_wdata !== e_wd[cyc]) begin
        n_fail++; $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, s_mem_wdata, e_wd[cyc]);
      end
    end
    n_checks++;
    if (s_rd_valid !== e_rv[cyc]) begin
      n_fail++; $display("FAIL rd_valid cyc=%0d got=%b exp=%b", cyc, s_rd_valid, e_rv[cyc]);
    end
    if (e_rv[cyc]) begin
      n_checks++;
      if (s_rd_data !== e_rd[cyc]) begin
        n_fail++; $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, s_rd_data, e_rd[cyc]);
      end
    end
    n_checks++;
    if (s_level !== (WFIFO_AW+1)'(sz)) begin
      n_fail++; $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, s_level, sz);
    end
    n_checks++;
    if (s_ovf !== m_ovf) begin
      n_fail++; $display("FAIL wr_ovf cyc=%0d got=%b exp=%b", cyc, s_ovf, m_ovf);
    end

    if (mw)      m_last = head.addr;
    else if (mr) m_last = rd_addr;
    e_we[cyc+1]   = mw;
    e_addr[cyc+1] = m_last;
    if (mw) begin
      e_oe[cyc+1+RD_LAT] = 1;
      e_wd[cyc+1+RD_LAT] = head.data;
      void'(m_q.pop_front());
    end
    if (mr) begin
      e_rv[cyc+2+RD_LAT] = 1;
      e_rd[cyc+2+RD_LAT] = zread(rd_addr);
    end
    drop = 0;
    if (wr_en) begin
      if (m_q.size() >= DEPTH) drop = 1;
      else begin
        nw = {wr_addr, wr_data};
        m_q.push_back(nw);
        wmem[wr_addr] = wr_data;
      end
    end
    if (drop)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (sz == 0 || mw) m_wait = 0;
    else               m_wait++;

    @(posedge clk); #1;
    cyc++;
    mem_rdata = (cyc >= RD_LAT) ? zread(zh_addr[cyc-RD_LAT]) : '0;
  endtask

  task automatic drain();
    int n = 0;
    wr_en = 0; ovf_clr = 0;
    while (rd_req && !s_rd_ack && n < 50) begin tick(); n++; end
    rd_req = 0;
    while (m_q.size() > 0 && n < 200) begin tick(); n++; end
    n_checks++;
    if (m_q.size() != 0 || n >= 200) begin
      n_fail++; $display("FAIL drain_timeout got_pending=%0d exp=0", m_q.size());
    end
    repeat (RD_LAT + 4) tick();
  endtask

  task automatic mem_compare(input string tag);
    foreach (wmem[a]) begin
      n_checks++;
      if (!zmem.exists(a) || zmem[a] !== wmem[a]) begin
        n_fail++;
        $display("FAIL %s_mem addr=%h got=%h exp=%h", tag, a,
                 zmem.exists(a) ? zmem[a] : 36'h0, wmem[a]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; wr_en = 0; rd_req = 0; ovf_clr = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    rd_req = 1; rd_addr = raddr(); wr_en = 1; wr_addr = waddr(); wr_data = rdat();
    tick();
    wr_en = 0; rd_addr = raddr();
    tick();
    rd_req = 0;
    tick();
    // two reads and one write are now in flight
    rd_req = 1;
    rst_n  = 0;
    #1;
    n_checks++;
    if ({rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata, mem_wdata_oe,
         wr_ovf, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b rv=%b rd=%h ma=%h we=%b wd=%h oe=%b ovf=%b lvl=%0d exp=all_zero",
               rd_ack, rd_valid, rd_data, mem_addr, mem_we, mem_wdata, mem_wdata_oe, wr_ovf, fifo_level);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    rd_req = 0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (s_rd_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_rd_valid i=%0d got=%b exp=0", i, s_rd_valid);
      end
    end
    n_checks++;
    if (s_level !== '0) begin
      n_fail++; $display("FAIL reset_fifo_level got=%0d exp=0", s_level);
    end
  endtask

  task automatic test_read_only();
    zmem[19'h00010] = 36'hABC;
    rd_req = 1; rd_addr = 19'h00010;
    tick();
    n_checks++;
    if (s_rd_ack !== 1'b1) begin n_fail++; $display("FAIL t2_ack got=%b exp=1", s_rd_ack); end
    rd_req = 0;
    tick();
    n_checks++;
    if (s_mem_addr !== 19'h00010 || s_mem_we !== 1'b0) begin
      n_fail++; $display("FAIL t2_addr got=%h/%b exp=00010/0", s_mem_addr, s_mem_we);
    end
    tick(); tick();
    n_checks++;
    if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL t2_early_valid got=%b exp=0", s_rd_valid); end
    tick();
    n_checks++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== 36'hABC) begin
      n_fail++; $display("FAIL t2_data got=%b/%h exp=1/abc", s_rd_valid, s_rd_data);
    end
    repeat (3) tick();
  endtask

  task automatic test_write_only();
    wr_en = 1; wr_addr = 19'h01234; wr_data = 36'h0DEADBEEF;
    tick();
    wr_en = 0;
    tick(); tick();
    n_checks++;
    if (s_mem_we !== 1'b1 || s_mem_addr !== 19'h01234) begin
      n_fail++; $display("FAIL t3_addr got=%b/%h exp=1/01234", s_mem_we, s_mem_addr);
    end
    tick();
    n_checks++;
    if (s_oe !== 1'b0) begin n_fail++; $display("FAIL t3_early_oe got=%b exp=0", s_oe); end
    tick();
    n_checks++;
    if (s_oe !== 1'b1 || s_mem_wdata !== 36'h0DEADBEEF) begin
      n_fail++; $display("FAIL t3_data got=%b/%h exp=1/0deadbeef", s_oe, s_mem_wdata);
    end
    repeat (3) tick();
  endtask

  task automatic test_starvation();
    rd_req = 1; rd_addr = raddr();
    wr_en = 1; wr_addr = waddr(); wr_data = rdat();
    tick();
    n_checks++;
    if (s_rd_ack !== 1'b1) begin n_fail++; $display("FAIL t4_ack0 got=%b exp=1", s_rd_ack); end
    wr_en = 0;
    for (int k = 1; k <= 18; k++) begin
      if (s_rd_ack) rd_addr = raddr();
      tick();
      n_checks++;
      if (s_rd_ack !== (k != 16)) begin
        n_fail++; $display("FAIL t4_ack k=%0d got=%b exp=%b", k, s_rd_ack, (k != 16));
      end
      if (k == 17) begin
        n_checks++;
        if (s_mem_we !== 1'b1) begin n_fail++; $display("FAIL t4_forced_we got=%b exp=1", s_mem_we); end
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    rd_req = 1; rd_addr = raddr();
    for (int i = 0; i < 9; i++) begin
      if (s_rd_ack) rd_addr = raddr();
      wr_en = 1; wr_addr = 19'h7F000 + 19'(i); wr_data = rdat();
      tick();
    end
    wr_en = 0;
    if (s_rd_ack) rd_addr = raddr();
    tick();
    n_checks++;
    if (s_level !== 4'd8 || s_ovf !== 1'b1) begin
      n_fail++; $display("FAIL t5_full got=%0d/%b exp=8/1", s_level, s_ovf);
    end
    if (s_rd_ack) rd_addr = raddr();
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    if (s_rd_ack) rd_addr = raddr();
    tick();
    n_checks++;
    if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL t5_clr got=%b exp=0", s_ovf); end
    drain();
    n_checks++;
    if (zmem.exists(19'h7F008)) begin
      n_fail++; $display("FAIL t5_dropped_written got=%h exp=absent", zmem[19'h7F008]);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 100; i++) begin
      if (!rd_req || s_rd_ack) begin
        rd_req  = (i % 2 == 0);
        rd_addr = raddr();
      end
      wr_en = (i % 2 == 1); wr_addr = waddr(); wr_data = rdat();
      tick();
    end
    drain();
    mem_compare("t6");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if (!rd_req || s_rd_ack) begin
        rd_req  = ($urandom_range(0, 1) == 1);
        rd_addr = raddr();
      end
      wr_en   = ($urandom_range(0, 9) < 6);
      wr_addr = waddr(); wr_data = rdat();
      ovf_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    drain();
    mem_compare("rand");
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_write_only();
    test_starvation();
    test_overflow();
    test_interleave();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
